// File: rtl/gba_rom_port_arbiter.sv
// gba_rom_port_arbiter
// Shares the single-port cartridge ROM BRAM between the GBA bus read path
// and a host loader port. GBA reads always win the BRAM. A 2-bit tag
// follows each read through the one-cycle BRAM latency so that the returned
// word lands in the requester that issued it.

module gba_rom_port_arbiter #(
    parameter int                 ADDR_W     = 12,
    parameter int                 DATA_W     = 16,
    parameter logic [DATA_W-1:0]  OOR_DATA   = '0,
    parameter bit                 LOCK_IN_CS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cs_fall,
    input  logic              rd_fall,
    input  logic              rd_rise,
    input  logic              cs_active,
    input  logic [15:0]       addr_in,
    output logic [15:0]       gba_addr,
    output logic [DATA_W-1:0] gba_data,
    output logic              gba_data_vld,

    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Destination of the read issued in the previous cycle. GBA_OOR marks a
    // GBA read past the BRAM depth, which never touches the BRAM.
    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_GBA     = 2'd1,
        TAG_GBA_OOR = 2'd2,
        TAG_HOST    = 2'd3
    } tag_t;

    tag_t issue_tag;
    tag_t tag_q;
    logic gba_in_range;
    logic host_fire;

    assign gba_in_range = ((gba_addr >> ADDR_W) == 16'd0);
    assign host_ready   = !rst && !rd_fall && !(LOCK_IN_CS && cs_active);
    assign host_fire    = host_valid && host_ready;

    // BRAM port steering: a GBA read strobe owns the port, otherwise an
    // accepted host request drives it.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        issue_tag = TAG_NONE;
        if (rd_fall) begin
            if (gba_in_range) begin
                mem_en    = 1'b1;
                mem_addr  = gba_addr[ADDR_W-1:0];
                issue_tag = TAG_GBA;
            end else begin
                issue_tag = TAG_GBA_OOR;
            end
        end else if (host_fire) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            issue_tag = host_we ? TAG_NONE : TAG_HOST;
        end
    end

    // GBA sequential address counter; an RD rising edge beats a CS load.
    always_ff @(posedge clk) begin
        if (rst) begin
            gba_addr <= 16'h0000;
        end else if (rd_rise) begin
            gba_addr <= gba_addr + 16'h0001;
        end else if (cs_fall) begin
            gba_addr <= addr_in;
        end
    end

    // Tag stage aligned with the cycle in which mem_rdata becomes valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= TAG_NONE;
        end else begin
            tag_q <= issue_tag;
        end
    end

    // Return stage: capture the BRAM word (or the out-of-range filler) into
    // the requester named by the tag and pulse its valid for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gba_data     <= '0;
            gba_data_vld <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
        end else begin
            gba_data_vld <= 1'b0;
            host_rvalid  <= 1'b0;
            case (tag_q)
                TAG_GBA: begin
                    gba_data     <= mem_rdata;
                    gba_data_vld <= 1'b1;
                end
                TAG_GBA_OOR: begin
                    gba_data     <= OOR_DATA;
                    gba_data_vld <= 1'b1;
                end
                TAG_HOST: begin
                    host_rdata  <= mem_rdata;
                    host_rvalid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
